// File: rtl/user_prng_obi.sv
// OBI subordinate exposing a 32-bit xorshift PRNG: DATA, SEED, CTRL (auto-run) and a DATA-read counter.
// Every request is granted at once and answered one cycle later.

// Minimal stand-in for the SoC package so this block elaborates on its own.
package croc_pkg;

  typedef struct packed {
    int unsigned addr_width;
    int unsigned data_width;
    int unsigned IdWidth;
  } obi_cfg_t;

  localparam obi_cfg_t SbrObiCfg = '{addr_width: 32, data_width: 32, IdWidth: 3};

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [2:0]  aid;
    logic        a_optional;
  } sbr_obi_a_chan_t;

  typedef struct packed {
    sbr_obi_a_chan_t a;
    logic            req;
  } sbr_obi_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic [2:0]  rid;
    logic        err;
    logic        r_optional;
  } sbr_obi_r_chan_t;

  typedef struct packed {
    sbr_obi_r_chan_t r;
    logic            gnt;
    logic            rvalid;
  } sbr_obi_rsp_t;

endpackage

module user_prng_obi #(
  parameter croc_pkg::obi_cfg_t ObiCfg      = croc_pkg::SbrObiCfg,
  parameter type                obi_req_t   = croc_pkg::sbr_obi_req_t,
  parameter type                obi_rsp_t   = croc_pkg::sbr_obi_rsp_t,
  parameter logic [31:0]        DefaultSeed = 32'h2545_F491
) (
  input  logic     clk_i,
  input  logic     rst_ni,
  input  obi_req_t obi_req_i,
  output obi_rsp_t obi_rsp_o
);

  localparam int unsigned IdW = ObiCfg.IdWidth;

  logic [31:0]    state_q, state_d;
  logic [31:0]    seed_q, seed_d;
  logic           auto_q, auto_d;
  logic [31:0]    count_q, count_d;

  logic           rvalid_q;
  logic [31:0]    rdata_q, rdata_d;
  logic [IdW-1:0] rid_q;
  logic           err_q, err_d;

  logic           req;
  logic           we;
  logic [3:0]     be;
  logic [31:0]    wdata;
  logic [9:0]     word_idx;
  logic           in_map;
  logic           sel_data, sel_seed, sel_ctrl, sel_count;
  logic           data_rd, seed_wr, ctrl_wr, count_wr;
  logic [31:0]    seed_merged;
  logic           unused_req_bits;

  function automatic logic [31:0] xorshift_step(input logic [31:0] x);
    logic [31:0] y;
    y = x ^ (x << 13);
    y = y ^ (y >> 17);
    y = y ^ (y << 5);
    return y;
  endfunction

  assign req      = obi_req_i.req;
  assign we       = obi_req_i.a.we;
  assign be       = obi_req_i.a.be;
  assign wdata    = obi_req_i.a.wdata;
  assign word_idx = obi_req_i.a.addr[11:2];

  // The demux already selected the window; the upper and byte-offset bits are don't-care here.
  assign unused_req_bits = ^{obi_req_i.a.addr[31:12], obi_req_i.a.addr[1:0], obi_req_i.a.a_optional};

  assign in_map    = (word_idx[9:2] == 8'd0);
  assign sel_data  = in_map && (word_idx[1:0] == 2'd0);
  assign sel_seed  = in_map && (word_idx[1:0] == 2'd1);
  assign sel_ctrl  = in_map && (word_idx[1:0] == 2'd2);
  assign sel_count = in_map && (word_idx[1:0] == 2'd3);

  assign data_rd  = req && sel_data && !we;
  assign seed_wr  = req && sel_seed && we;
  assign ctrl_wr  = req && sel_ctrl && we && be[0];
  assign count_wr = req && sel_count && we;

  always_comb begin
    seed_merged = seed_q;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) seed_merged[8*b +: 8] = wdata[8*b +: 8];
    end
  end

  // A zero seed would lock the generator at zero, so it is replaced by DefaultSeed.
  always_comb begin
    state_d = state_q;
    seed_d  = seed_q;
    auto_d  = auto_q;
    count_d = count_q;
    if (seed_wr) begin
      seed_d  = seed_merged;
      state_d = (seed_merged == 32'd0) ? DefaultSeed : seed_merged;
    end else if (data_rd || auto_q) begin
      state_d = xorshift_step(state_q);
    end
    if (ctrl_wr) auto_d = wdata[0];
    if (count_wr) begin
      count_d = 32'd0;
    end else if (data_rd) begin
      count_d = count_q + 32'd1;
    end
  end

  always_comb begin
    err_d   = 1'b0;
    rdata_d = 32'd0;
    if (req) begin
      if (!in_map || (sel_data && we)) begin
        err_d = 1'b1;
      end else if (!we) begin
        unique case (word_idx[1:0])
          2'd0:    rdata_d = state_q;
          2'd1:    rdata_d = seed_q;
          2'd2:    rdata_d = {31'd0, auto_q};
          default: rdata_d = count_q;
        endcase
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= DefaultSeed;
      seed_q  <= DefaultSeed;
      auto_q  <= 1'b0;
      count_q <= 32'd0;
    end else begin
      state_q <= state_d;
      seed_q  <= seed_d;
      auto_q  <= auto_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rvalid_q <= 1'b0;
      rdata_q  <= 32'd0;
      rid_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      rvalid_q <= req;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      if (req) rid_q <= obi_req_i.a.aid;
    end
  end

  always_comb begin
    obi_rsp_o              = '0;
    obi_rsp_o.gnt          = req;
    obi_rsp_o.rvalid       = rvalid_q;
    obi_rsp_o.r.rdata      = rdata_q;
    obi_rsp_o.r.rid        = rid_q;
    obi_rsp_o.r.err        = err_q;
    obi_rsp_o.r.r_optional = 1'b0;
  end

endmodule

// File: tb/tb_user_prng_obi.sv
// Bench for user_prng_obi: directed scenarios plus random traffic against a
// register-level model of the PRNG block.
module tb_user_prng_obi;

  localparam logic [31:0] DEF = 32'h2545_F491;

  logic                   clk_i;
  logic                   rst_ni;
  croc_pkg::sbr_obi_req_t obi_req_i;
  croc_pkg::sbr_obi_rsp_t obi_rsp_o;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] m_state, m_seed, m_count;
  logic        m_auto;
  logic [31:0] rd;

  user_prng_obi dut (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .obi_req_i (obi_req_i),
    .obi_rsp_o (obi_rsp_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] xs(input logic [31:0] x);
    logic [31:0] v;
    v = x;
    v = v ^ (v << 13);
    v = v ^ (v >> 17);
    v = v ^ (v << 5);
    return v;
  endfunction

  task automatic model_reset();
    m_state = DEF;
    m_seed  = DEF;
    m_auto  = 1'b0;
    m_count = 32'd0;
  endtask

  // One bus cycle: drive (at posedge+1), predict, then check the response one cycle later.
  task automatic bus_cycle(input bit rq, input logic [11:0] off, input bit w,
                           input logic [3:0] be, input logic [31:0] wdata,
                           input logic [2:0] aid, output logic [31:0] rdata);
    logic [31:0] exp_rd, merged, nxt_state;
    logic        exp_err, is_data, is_seed, is_ctrl, is_cnt;
    obi_req_i             = '0;
    obi_req_i.req         = rq;
    obi_req_i.a.addr      = 32'h2000_2000 | {20'd0, off};
    obi_req_i.a.we        = w;
    obi_req_i.a.be        = be;
    obi_req_i.a.wdata     = wdata;
    obi_req_i.a.aid       = aid;
    is_data = rq && (off == 12'h000);
    is_seed = rq && (off == 12'h004);
    is_ctrl = rq && (off == 12'h008);
    is_cnt  = rq && (off == 12'h00C);
    exp_err = rq && ((off >= 12'h010) || (is_data && w));
    exp_rd  = 32'd0;
    if (rq && !exp_err && !w) begin
      if (is_data) exp_rd = m_state;
      if (is_seed) exp_rd = m_seed;
      if (is_ctrl) exp_rd = {31'd0, m_auto};
      if (is_cnt)  exp_rd = m_count;
    end
    nxt_state = m_state;
    if (is_seed && w) begin
      merged = m_seed;
      for (int b = 0; b < 4; b++) if (be[b]) merged[8*b +: 8] = wdata[8*b +: 8];
      m_seed    = merged;
      nxt_state = (merged == 0) ? DEF : merged;
    end else if ((is_data && !w) || m_auto) begin
      nxt_state = xs(m_state);
    end
    m_state = nxt_state;
    if (is_ctrl && w && be[0]) m_auto = wdata[0];
    if (is_cnt && w) m_count = 0;
    else if (is_data && !w) m_count = m_count + 1;
    #1;
    check_val("gnt", {31'd0, obi_rsp_o.gnt}, {31'd0, rq});
    @(posedge clk_i);
    #1;
    check_val("rvalid", {31'd0, obi_rsp_o.rvalid}, {31'd0, rq});
    if (rq) begin
      check_val("rdata", obi_rsp_o.r.rdata, exp_rd);
      check_val("err", {31'd0, obi_rsp_o.r.err}, {31'd0, exp_err});
      check_val("rid", {29'd0, obi_rsp_o.r.rid}, {29'd0, aid});
    end
    rdata = obi_rsp_o.r.rdata;
  endtask

  task automatic rd_reg(input logic [11:0] off, output logic [31:0] rdata);
    bus_cycle(1'b1, off, 1'b0, 4'hF, 32'd0, 3'd0, rdata);
  endtask

  task automatic wr_reg(input logic [11:0] off, input logic [3:0] be, input logic [31:0] wdata);
    logic [31:0] dummy;
    bus_cycle(1'b1, off, 1'b1, be, wdata, 3'd0, dummy);
  endtask

  task automatic idle();
    logic [31:0] dummy;
    bus_cycle(1'b0, 12'h000, 1'b0, 4'h0, 32'd0, 3'd0, dummy);
  endtask

  initial begin
    logic [31:0] st_before, cnt_before;
    obi_req_i = '0;
    rst_ni    = 1'b0;
    model_reset();
    repeat (2) @(posedge clk_i);
    #1;
    check_val("rst_rvalid", {31'd0, obi_rsp_o.rvalid}, 32'd0);
    check_val("rst_rdata", obi_rsp_o.r.rdata, 32'd0);
    check_val("rst_rid", {29'd0, obi_rsp_o.r.rid}, 32'd0);
    check_val("rst_err", {31'd0, obi_rsp_o.r.err}, 32'd0);
    rst_ni = 1'b1;

    rd_reg(12'h000, rd); check_val("data0_const", rd, 32'h2545_F491);
    rd_reg(12'h000, rd); check_val("data1_const", rd, xs(32'h2545_F491));
    rd_reg(12'h00C, rd); check_val("count2_const", rd, 32'd2);

    wr_reg(12'h004, 4'hF, 32'd1);
    rd_reg(12'h000, rd); check_val("seed1_a", rd, 32'h0000_0001);
    rd_reg(12'h000, rd); check_val("seed1_b", rd, 32'h0004_2021);
    rd_reg(12'h000, rd); check_val("seed1_c", rd, 32'h0408_0601);

    wr_reg(12'h004, 4'hF, 32'd0);
    rd_reg(12'h004, rd); check_val("seed0_raw", rd, 32'd0);
    rd_reg(12'h000, rd); check_val("seed0_subst", rd, DEF);
    wr_reg(12'h004, 4'h1, 32'hFFFF_FF05);
    rd_reg(12'h004, rd); check_val("seed_be1", rd, 32'h0000_0005);

    wr_reg(12'h004, 4'hF, 32'd1);
    wr_reg(12'h008, 4'hF, 32'd1);
    idle(); idle();
    rd_reg(12'h000, rd); check_val("auto_2step", rd, 32'h0408_0601);
    wr_reg(12'h008, 4'hF, 32'd0);
    st_before = m_state;
    idle(); idle(); idle();
    rd_reg(12'h000, rd); check_val("auto_off_hold", rd, st_before);

    st_before  = m_state;
    cnt_before = m_count;
    wr_reg(12'h000, 4'hF, 32'hDEAD_BEEF);
    bus_cycle(1'b1, 12'h010, 1'b0, 4'hF, 32'd0, 3'd5, rd);
    bus_cycle(1'b1, 12'hFFC, 1'b0, 4'hF, 32'd0, 3'd6, rd);
    rd_reg(12'h00C, rd); check_val("err_count_kept", rd, cnt_before);
    rd_reg(12'h000, rd); check_val("err_state_kept", rd, st_before);

    bus_cycle(1'b1, 12'h000, 1'b0, 4'hF, 32'd0,  3'd1, rd);
    bus_cycle(1'b1, 12'h00C, 1'b1, 4'h0, 32'd77, 3'd2, rd);
    bus_cycle(1'b1, 12'h00C, 1'b0, 4'hF, 32'd0,  3'd3, rd);
    check_val("b2b_count0", rd, 32'd0);

    for (int i = 0; i < 400; i++) begin
      logic [11:0] off;
      logic [31:0] wd;
      bit          rq, w;
      rq  = ($urandom_range(0, 9) != 0);
      off = ($urandom_range(0, 9) == 0) ? {$urandom_range(4, 1023), 2'b00} : {8'd0, 2'($urandom_range(0, 3)), 2'b00};
      w   = ($urandom_range(0, 3) == 0);
      if (off == 12'h00C && w && $urandom_range(0, 2) != 0) w = 1'b0;
      wd  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      bus_cycle(rq, off, w, 4'($urandom_range(0, 15)), wd, 3'($urandom_range(0, 7)), rd);
    end
    wr_reg(12'h008, 4'hF, 32'd0);

    obi_req_i = '0;
    bus_cycle(1'b1, 12'h000, 1'b0, 4'hF, 32'd0, 3'd4, rd);
    obi_req_i = '0;
    bus_cycle(1'b1, 12'h000, 1'b0, 4'hF, 32'd0, 3'd4, rd);
    obi_req_i = '0;
    #1;
    // A request accepted at the edge just passed has its response pending on the bus now.
    obi_req_i.req = 1'b1;
    @(posedge clk_i);
    #1;
    obi_req_i = '0;
    check_val("pre_rst_rvalid", {31'd0, obi_rsp_o.rvalid}, 32'd1);
    rst_ni = 1'b0;
    #1;
    check_val("async_rst_rvalid", {31'd0, obi_rsp_o.rvalid}, 32'd0);
    model_reset();
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    idle();
    rd_reg(12'h000, rd); check_val("post_rst_data", rd, DEF);
    rd_reg(12'h00C, rd); check_val("post_rst_count", rd, 32'd1);
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/user_prng_obi.md
# user_prng_obi

OBI subordinate for the user domain that exposes a 32-bit xorshift pseudo-random generator. It sits on the `UserPrng` output of the user-domain OBI demux and serves the 4 KB window at `UserPrngAddrOffset` (0x2000_2000). Software seeds it, reads random words (each read advances the generator), optionally lets it free-run, and reads a wrapping read counter. Every request is granted immediately and answered exactly one cycle later.

## Interface

Parameters:
- `ObiCfg`, default `croc_pkg::SbrObiCfg`: OBI configuration; sets the ID width.
- `obi_req_t`, default `croc_pkg::sbr_obi_req_t`: request struct type.
- `obi_rsp_t`, default `croc_pkg::sbr_obi_rsp_t`: response struct type.
- `DefaultSeed`, default 32'h2545_F491: reset state, and the substitute used whenever a zero seed is written.

Ports:
- `clk_i`  in  1: single clock; every register is on its rising edge.
- `rst_ni`  in  1: asynchronous, active-low reset.
- `obi_req_i`  in  struct: uses `req`, `a.addr[31:0]`, `a.we`, `a.be[3:0]`, `a.wdata[31:0]`, `a.aid`.
- `obi_rsp_o`  out  struct: drives `gnt`, `rvalid`, `r.rdata[31:0]`, `r.rid`, `r.err`; `r.r_optional` is tied to 0.

## Operation

- Register map, decoded on `addr[11:2]`. Only word offsets 0–3 are valid.
- 0x0 DATA (RO):
  - Read returns the current `state`; `state` then advances one xorshift step.
  - Write: error response, no side effect.
- 0x4 SEED (RW):
  - Write merges byte-wise per `be` into `seed_q`.
  - In the same cycle, `state` is loaded with the merged value, or with `DefaultSeed` if the merged value is 0.
  - Read returns `seed_q`, the raw merged value, which can be 0.
- 0x8 CTRL (RW):
  - Bit 0 is AUTO: when 1, `state` advances every cycle.
  - Write updates bit 0 only when `be[0]`=1. Bits 31:1 read 0.
- 0xC COUNT (RO/clear):
  - Read returns the number of DATA reads, 32-bit, wrapping 0xFFFF_FFFF→0.
  - Write of any data or `be` clears it to 0.
- Any other offset in the window: error response, `rdata`=0, no side effect.
- Error responses set `err`=1 in the response cycle; `rdata`=0.
- Xorshift step, all 32-bit with truncating shifts:
  - x ^= x<<13
  - x ^= x>>17
  - x ^= x<<5
- `state` can never be 0: a zero seed is substituted, and the step preserves nonzero values.
- Next-state priority for `state`, highest first:
  - SEED write.
  - Single step, if a DATA read or AUTO=1. A DATA read with AUTO=1 steps once, not twice.
  - Hold.
- COUNT priority, highest first: COUNT write clears, then DATA read increments, then hold.
- A DATA read returns the pre-step value. An accepted error request changes no state.

## Timing

- `gnt` = `req` combinationally, with no wait states.
- Accepted request in cycle N → response in cycle N+1:
  - `rvalid`=1.
  - `rid` = `aid` captured at N.
  - `rdata`/`err` registered at N.
- Back-to-back requests are sustained at one per cycle. `rvalid` is high in every cycle following an accepted request.
- Register updates from a write in cycle N are visible to a read issued in cycle N+1.
- Reset values:
  - `state` = `DefaultSeed`, `seed_q` = `DefaultSeed`.
  - CTRL = 0, COUNT = 0.
  - `rvalid`=0, `rdata`=0, `rid`=0, `err`=0.
- Reset asserted mid-transaction: a pending response is dropped and `rvalid` goes 0 asynchronously. After release, no response is issued for the pre-reset request.

## Test plan

- Reset, then read DATA twice → 0x2545_F491, then its xorshift successor. Then read COUNT → 2.
- Write SEED=0x0000_0001 (`be`=0xF), then read DATA three times → 0x0000_0001, 0x0004_2021, 0x0408_0601.
- Write SEED=0 → SEED reads 0. DATA reads 0x2545_F491. Write SEED with `be`=0x1, wdata=0xFFFF_FF05, from `seed_q`=0 → `seed_q`=0x0000_0005.
- Write SEED=1, write CTRL=1, idle 2 cycles, then read DATA → the value 2 steps after the last state observed. Write CTRL=0 → state holds across idle cycles.
- Errors, each with `err`=1, `rdata`=0, and state/COUNT unchanged:
  - Write DATA.
  - Read offset 0x010.
  - Read offset 0xFFC.
- Issue back-to-back requests with distinct `aid` values: DATA read, COUNT write, COUNT read → `rvalid` on three consecutive cycles, `rid`s echoed in order, COUNT read returns 0. Assert reset with a response pending → `rvalid`=0 immediately.
